// File: rtl/accel_resp_pkg.sv
// Shared constants, register map and FSM states for the SPI accelerometer responder.
package accel_resp_pkg;

  localparam logic [7:0] CMD_WRITE      = 8'h0A;
  localparam logic [7:0] CMD_READ       = 8'h0B;
  localparam logic [7:0] SOFT_RESET_KEY = 8'h52;
  localparam logic [7:0] REVID          = 8'h02;
  localparam logic [7:0] POWER_CTL_RST  = 8'h00;
  localparam logic [7:0] FILTER_CTL_RST = 8'h13;

  localparam logic [5:0] ADDR_DEVID_AD  = 6'h00;
  localparam logic [5:0] ADDR_DEVID_MST = 6'h01;
  localparam logic [5:0] ADDR_PARTID    = 6'h02;
  localparam logic [5:0] ADDR_REVID     = 6'h03;
  localparam logic [5:0] ADDR_XDATA     = 6'h08;
  localparam logic [5:0] ADDR_YDATA     = 6'h09;
  localparam logic [5:0] ADDR_ZDATA     = 6'h0A;
  localparam logic [5:0] ADDR_STATUS    = 6'h0B;
  localparam logic [5:0] ADDR_XDATA_L   = 6'h0E;
  localparam logic [5:0] ADDR_XDATA_H   = 6'h0F;
  localparam logic [5:0] ADDR_YDATA_L   = 6'h10;
  localparam logic [5:0] ADDR_YDATA_H   = 6'h11;
  localparam logic [5:0] ADDR_ZDATA_L   = 6'h12;
  localparam logic [5:0] ADDR_ZDATA_H   = 6'h13;
  localparam logic [5:0] ADDR_SOFT_RST  = 6'h1F;
  localparam logic [5:0] ADDR_FILTER    = 6'h2C;
  localparam logic [5:0] ADDR_POWER     = 6'h2D;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD, WR, IGNORE} state_e;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] z;
  } accel_sample_t;

  // Upper byte of a 12-bit sample as the part presents it: sign-extended nibble.
  function automatic logic [7:0] sext_hi(input logic [11:0] v);
    return {{4{v[11]}}, v[11:8]};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchronizes sclk/ss/mosi into the system clock and flags sclk and ss edges.
module spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sclk,
  input  logic ss,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic ss_fall,
  output logic ss_rise,
  output logic ss_n_s,
  output logic mosi_s
);

  localparam int NSIG = 3;  // 0: sclk, 1: ss, 2: mosi

  logic [NSIG-1:0]                  pins;
  logic [NSIG-1:0][SYNC_STAGES-1:0] sync_q;
  logic [1:0]                       dly_q;
  logic                             sclk_s;

  assign pins = {mosi, ss, sclk};

  // ss resets to "selected" so a transaction already running at reset release
  // never produces an ss_fall; only a genuine new select restarts decoding.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      for (int i = 0; i < NSIG; i++)
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pins[i]};
      dly_q <= {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};
    end
  end

  assign sclk_s    = sync_q[0][SYNC_STAGES-1];
  assign ss_n_s    = sync_q[1][SYNC_STAGES-1];
  assign mosi_s    = sync_q[2][SYNC_STAGES-1];
  assign sclk_rise =  sclk_s & ~dly_q[0];
  assign sclk_fall = ~sclk_s &  dly_q[0];
  assign ss_fall   = ~ss_n_s &  dly_q[1];
  assign ss_rise   =  ss_n_s & ~dly_q[1];

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 slave emulating an ADXL362 register subset, oversampled on the system clock.
module spi_accel_responder
  import accel_resp_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] DEVID_AD    = 8'hAD,
  parameter logic [7:0] DEVID_MST   = 8'h1D,
  parameter logic [7:0] PARTID      = 8'hF2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sclk,
  input  logic        ss,
  input  logic        mosi,
  output logic        miso,
  input  logic [11:0] accel_x,
  input  logic [11:0] accel_y,
  input  logic [11:0] accel_z,
  output logic [7:0]  power_ctl,
  output logic [7:0]  filter_ctl,
  output logic        measuring,
  output logic        err_cmd
);

  logic sclk_rise, sclk_fall, ss_fall, ss_rise, ss_n_s, mosi_s;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clock     (clock),
    .reset     (reset),
    .sclk      (sclk),
    .ss        (ss),
    .mosi      (mosi),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .ss_n_s    (ss_n_s),
    .mosi_s    (mosi_s)
  );

  state_e        state_q, state_d;
  logic [2:0]    bitcnt;
  logic [6:0]    rx_sr;
  logic [7:0]    rx_byte;
  logic [7:0]    tx_sr;
  logic [7:0]    rd_data;
  logic [5:0]    addr;
  logic          is_read;
  logic          err_d;
  logic          wr_en;
  logic          shift_ok;
  logic          byte_done;
  accel_sample_t snap;

  assign rx_byte   = {rx_sr, mosi_s};
  assign byte_done = sclk_rise && (bitcnt == 3'd7);
  // ss_fall wins over any coincident sclk edge; ss_rise already implies ss_n_s.
  assign shift_ok  = !ss_n_s && !ss_fall && (state_q != IDLE);
  assign measuring = (power_ctl[1:0] == 2'b10);
  assign miso      = (state_q == RD) ? tx_sr[7] : 1'b0;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    if (ss_fall) begin
      state_d = CMD;
    end else if (ss_rise) begin
      state_d = IDLE;
    end else if (shift_ok && byte_done) begin
      case (state_q)
        CMD: begin
          if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
            state_d = ADDR;
          end else begin
            state_d = IGNORE;
            err_d   = 1'b1;
          end
        end
        ADDR:    state_d = is_read ? RD : WR;
        WR:      wr_en   = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_DEVID_AD:  rd_data = DEVID_AD;
      ADDR_DEVID_MST: rd_data = DEVID_MST;
      ADDR_PARTID:    rd_data = PARTID;
      ADDR_REVID:     rd_data = REVID;
      ADDR_XDATA:     rd_data = snap.x[11:4];
      ADDR_YDATA:     rd_data = snap.y[11:4];
      ADDR_ZDATA:     rd_data = snap.z[11:4];
      ADDR_STATUS:    rd_data = {7'b0, measuring};
      ADDR_XDATA_L:   rd_data = snap.x[7:0];
      ADDR_XDATA_H:   rd_data = sext_hi(snap.x);
      ADDR_YDATA_L:   rd_data = snap.y[7:0];
      ADDR_YDATA_H:   rd_data = sext_hi(snap.y);
      ADDR_ZDATA_L:   rd_data = snap.z[7:0];
      ADDR_ZDATA_H:   rd_data = sext_hi(snap.z);
      ADDR_FILTER:    rd_data = filter_ctl;
      ADDR_POWER:     rd_data = power_ctl;
      default:        rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      bitcnt     <= 3'd0;
      rx_sr      <= '0;
      tx_sr      <= '0;
      addr       <= '0;
      is_read    <= 1'b0;
      snap       <= '0;
      power_ctl  <= POWER_CTL_RST;
      filter_ctl <= FILTER_CTL_RST;
      err_cmd    <= 1'b0;
    end else begin
      state_q <= state_d;
      err_cmd <= err_d;
      if (ss_fall) begin
        snap   <= '{x: accel_x, y: accel_y, z: accel_z};
        bitcnt <= 3'd0;
        tx_sr  <= '0;
      end else if (ss_rise) begin
        bitcnt <= 3'd0;
        tx_sr  <= '0;
      end else if (shift_ok) begin
        if (sclk_rise) begin
          rx_sr  <= rx_byte[6:0];
          bitcnt <= bitcnt + 3'd1;
        end
        if (byte_done) begin
          case (state_q)
            CMD:     is_read <= (rx_byte == CMD_READ);
            ADDR:    addr    <= rx_byte[5:0];
            WR:      addr    <= addr + 6'd1;
            default: ;
          endcase
        end
        // Loading on the fall that precedes a byte puts bit 7 on miso before its first rise.
        if (sclk_fall && state_q == RD) begin
          if (bitcnt == 3'd0) begin
            tx_sr <= rd_data;
            addr  <= addr + 6'd1;
          end else begin
            tx_sr <= {tx_sr[6:0], 1'b0};
          end
        end
      end
      if (wr_en) begin
        case (addr)
          ADDR_FILTER: filter_ctl <= rx_byte;
          ADDR_POWER:  power_ctl  <= rx_byte;
          ADDR_SOFT_RST: begin
            if (rx_byte == SOFT_RESET_KEY) begin
              power_ctl  <= POWER_CTL_RST;
              filter_ctl <= FILTER_CTL_RST;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_accel_responder.sv
// Directed and randomized SPI master bench for spi_accel_responder with a register-map model.
module tb_spi_accel_responder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sclk  = 1'b0;
  logic        ss    = 1'b1;
  logic        mosi  = 1'b0;
  logic        miso;
  logic [11:0] accel_x = '0, accel_y = '0, accel_z = '0;
  logic [7:0]  power_ctl, filter_ctl;
  logic        measuring, err_cmd;

  spi_accel_responder dut (
    .clock      (clock),
    .reset      (reset),
    .sclk       (sclk),
    .ss         (ss),
    .mosi       (mosi),
    .miso       (miso),
    .accel_x    (accel_x),
    .accel_y    (accel_y),
    .accel_z    (accel_z),
    .power_ctl  (power_ctl),
    .filter_ctl (filter_ctl),
    .measuring  (measuring),
    .err_cmd    (err_cmd)
  );

  always #10 clock = ~clock;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int err_cnt = 0;

  always @(negedge clock) if (err_cmd === 1'b1) err_cnt++;

  // Reference model: what the master believes the device holds.
  logic [7:0]  m_power  = 8'h00;
  logic [7:0]  m_filter = 8'h13;
  logic [11:0] sx = '0, sy = '0, sz = '0;

  function automatic logic [7:0] m_read(input int a);
    logic [11:0] v;
    int          k;
    a = a % 64;
    case (a)
      0: return 8'hAD;
      1: return 8'h1D;
      2: return 8'hF2;
      3: return 8'h02;
      8: return sx[11:4];
      9: return sy[11:4];
      10: return sz[11:4];
      11: return (m_power[1:0] == 2'b10) ? 8'h01 : 8'h00;
      14, 15, 16, 17, 18, 19: begin
        k = (a - 14) / 2;
        v = (k == 0) ? sx : (k == 1) ? sy : sz;
        if (a % 2 == 0) return v[7:0];
        return {{4{v[11]}}, v[11:8]};
      end
      44: return m_filter;
      45: return m_power;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ncyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    ncyc(5);
    sclk = 1'b1;
    r = miso;
    ncyc(5);
    sclk = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    logic r;
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_bit(tx[7-i], r);
      rx = {rx[6:0], r};
    end
  endtask

  task automatic send(input logic [7:0] tx);
    logic [7:0] junk;
    xfer(tx, 8, junk);
  endtask

  task automatic ss_begin();
    sx = accel_x; sy = accel_y; sz = accel_z;
    ss = 1'b0;
    ncyc(8);
  endtask

  task automatic ss_end();
    ncyc(5);
    ss = 1'b1;
    mosi = 1'b0;
    ncyc(8);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    ss_begin(); send(8'h0A); send(a); send(d); ss_end();
  endtask

  task automatic rd_burst(input string tag, input int a, input int n);
    logic [7:0] rx;
    ss_begin(); send(8'h0B); send(a[7:0]);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, 8, rx);
      check(tag, {24'd0, rx}, {24'd0, m_read(a + i)});
    end
    ss_end();
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] fv, pv;

    ncyc(4);
    reset = 1'b0;
    ncyc(12);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_power", {24'd0, power_ctl}, 32'h00);
    check("rst_filter", {24'd0, filter_ctl}, 32'h13);
    check("rst_measuring", {31'd0, measuring}, 32'd0);
    check("rst_err", {31'd0, err_cmd}, 32'd0);

    // 1) identification registers
    rd_burst("devid_burst", 0, 4);
    check("t1_measuring", {31'd0, measuring}, 32'd0);

    // 2) enable measurement
    wr_reg(8'h2D, 8'h02); m_power = 8'h02;
    rd_burst("power_rb", 8'h2D, 1);
    check("t2_power", {24'd0, power_ctl}, 32'h02);
    check("t2_measuring", {31'd0, measuring}, 32'd1);
    rd_burst("status", 8'h0B, 1);

    // 3) snapshot held through the transaction
    accel_x = 12'hF23;
    ss_begin(); send(8'h0B);
    accel_x = 12'h456;
    send(8'h0E);
    xfer(8'h00, 8, rx); check("snap_xl", {24'd0, rx}, 32'h23);
    xfer(8'h00, 8, rx); check("snap_xh", {24'd0, rx}, 32'hFF);
    ss_end();
    rd_burst("new_snap", 8'h0E, 2);
    check("t3_err_none", err_cnt, 0);

    // 4) bad command
    ss_begin();
    xfer(8'h55, 8, rx); check("bad_cmd_miso0", {24'd0, rx}, 32'h00);
    xfer(8'h2D, 8, rx); check("bad_cmd_miso1", {24'd0, rx}, 32'h00);
    xfer(8'h00, 8, rx); check("bad_cmd_miso2", {24'd0, rx}, 32'h00);
    ss_end();
    check("err_pulse_width", err_cnt, 1);
    check("t4_power", {24'd0, power_ctl}, {24'd0, m_power});
    check("t4_filter", {24'd0, filter_ctl}, {24'd0, m_filter});

    // 5) partial byte dropped
    ss_begin(); send(8'h0A); send(8'h2C); xfer(8'hFF, 5, rx); ss_end();
    check("partial_filter", {24'd0, filter_ctl}, 32'h13);
    rd_burst("after_partial", 8'h2C, 2);

    // reset mid-transaction: remainder of that transaction is ignored
    ss_begin(); send(8'h0A); send(8'h2C);
    @(negedge clock); reset = 1'b1; ncyc(2); reset = 1'b0;
    m_power = 8'h00; m_filter = 8'h13;
    send(8'h77);
    ss_end();
    check("midrst_filter", {24'd0, filter_ctl}, 32'h13);
    check("midrst_power", {24'd0, power_ctl}, 32'h00);

    // 6) soft reset key and address wrap
    wr_reg(8'h2D, 8'h02); m_power = 8'h02;
    wr_reg(8'h2C, 8'h55); m_filter = 8'h55;
    check("pre_sr_power", {24'd0, power_ctl}, 32'h02);
    wr_reg(8'h1F, 8'h51);
    check("bad_key_filter", {24'd0, filter_ctl}, 32'h55);
    wr_reg(8'h1F, 8'h52); m_power = 8'h00; m_filter = 8'h13;
    check("sr_power", {24'd0, power_ctl}, 32'h00);
    check("sr_filter", {24'd0, filter_ctl}, 32'h13);
    rd_burst("wrap", 8'h3F, 2);

    // randomized samples, burst writes and burst reads
    for (int it = 0; it < 6; it++) begin
      accel_x = 12'($urandom); accel_y = 12'($urandom); accel_z = 12'($urandom);
      fv = 8'($urandom); pv = 8'($urandom);
      ss_begin(); send(8'h0A); send(8'h2C); send(fv); send(pv); ss_end();
      m_filter = fv; m_power = pv;
      check("rnd_filter", {24'd0, filter_ctl}, {24'd0, fv});
      check("rnd_measuring", {31'd0, measuring}, {31'd0, pv[1:0] == 2'b10});
      rd_burst("rnd_data", 8 + int'($urandom_range(0, 11)), 3);
      rd_burst("rnd_any", int'($urandom_range(0, 63)), 3);
    end
    check("err_total", err_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
